uart_tx_feeder: RTL and testbench

Transmit-side buffer that sits directly upstream of the UART transmitter. It accepts 7-bit characters from the CPU at any rate, stores them in a small FIFO, and presents them one at a time on the transmitter's `datain_tx`/`tx_start` inputs. The transmitter has no busy or done output and samples `datain_tx` live for the whole frame, so the feeder times each frame itself and holds `datain_tx` stable until the frame window closes.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_tx_feeder.sv | 131 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the character width, bit timing, frame length and the state encoding
// of the transmit feeder FSM. No ports; imported by the UART-side modules.
package uart_pkg;

  localparam int DATA_W     = 7;
  localparam int BAUD_TICKS = 521;
  // start + 7 data + parity + stop = 10 bits (5210 cycles), rounded up for margin
  localparam int FRAME_CYCLES = 5500;
  localparam int TIMER_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular FIFO with explicit occupancy counter.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (pointers/count only)
//   push, wr_data - write request and data; accepted when not full, or when
//                   a pop happens in the same cycle
//   pop           - remove head entry; ignored when empty
//   flush         - clear all entries; wins over push
//   rd_data       - head entry (first-word fall-through)
//   full, empty, count - registered occupancy status
module sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Transmit-side buffer feeding the UART transmitter.
// Queues CPU characters and presents them one per frame window; since the
// transmitter has no busy/done output, the frame is timed here and datain_tx
// is held until the window (plus idle gap) closes.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   wr_en, wr_data    - CPU write strobe and character
//   flush             - discard queued characters (frame in flight continues)
//   full, empty, count- FIFO status
//   overflow          - sticky: a write was dropped on a full FIFO
//   busy              - frame window or gap in progress
//   tx_start          - one-cycle start pulse to the transmitter
//   datain_tx         - character for the transmitter, stable per frame
module uart_tx_feeder #(
  parameter int DATA_W       = uart_pkg::DATA_W,
  parameter int DEPTH        = 8,
  parameter int FRAME_CYCLES = uart_pkg::FRAME_CYCLES,
  parameter int GAP_CYCLES   = 16,
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] datain_tx
);

  import uart_pkg::feeder_state_e;
  import uart_pkg::IDLE;
  import uart_pkg::HOLD;
  import uart_pkg::GAP;
  import uart_pkg::TIMER_W;

  localparam logic [TIMER_W-1:0] FRAME_LAST = TIMER_W'(FRAME_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST   = TIMER_W'(GAP_CYCLES - 1);

  feeder_state_e      state;
  feeder_state_e      state_n;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_n;
  logic               start_n;
  logic               pop;
  logic [DATA_W-1:0]  head;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_en),
    .wr_data (wr_data),
    .pop     (pop),
    .flush   (flush),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    timer_n = timer;
    start_n = 1'b0;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          start_n = 1'b1;
          timer_n = '0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (timer == FRAME_LAST) begin
          timer_n = '0;
          state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      GAP: begin
        if (timer == GAP_LAST) begin
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      tx_start  <= 1'b0;
      datain_tx <= '0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      tx_start <= start_n;
      if (pop) datain_tx <= head;
    end
  end

  // A write dropped by flush does not count as an overflow; a write to a full
  // FIFO in the same cycle as a pop is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_en && !flush && full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

  localparam int DW    = 7;
  localparam int DEPTH = 8;
  localparam int F     = 40;
  localparam int G     = 4;
  localparam int PER   = F + G + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full, empty, overflow, busy, tx_start;
  logic [3:0]    count;
  logic [DW-1:0] datain_tx;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DATA_W       (DW),
    .DEPTH        (DEPTH),
    .FRAME_CYCLES (F),
    .GAP_CYCLES   (G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .flush     (flush),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .busy      (busy),
    .tx_start  (tx_start),
    .datain_tx (datain_tx)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;
  exp_t exp_q[$];

  // Reference: a queue of accepted characters plus the edge of the last pop.
  // A character may leave once a full frame period has elapsed since the last one.
  logic [DW-1:0] mq[$];
  bit            m_ovf  = 1'b0;
  bit            m_have = 1'b0;
  int            m_last = 0;
  logic [DW-1:0] m_dtx  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic step(input bit w, input logic [DW-1:0] d, input bit f, input bit r);
    bit   pop;
    exp_t e;
    @(negedge clk);
    wr_en = w; wr_data = d; flush = f; rst = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_have = 1'b0;
      m_dtx  = '0;
    end else begin
      pop = (mq.size() > 0) && (!m_have || cyc >= m_last + PER);
      if (pop) begin
        m_dtx  = mq.pop_front();
        m_have = 1'b1;
        m_last = cyc;
        e.d = m_dtx;
        e.c = cyc;
        exp_q.push_back(e);
      end
      if (f) mq.delete();
      else if (w) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    #1;
    chk("tx_start",  tx_start,  32'(m_have && cyc == m_last));
    chk("datain_tx", datain_tx, 32'(m_dtx));
    chk("count",     count,     32'(mq.size()));
    chk("full",      full,      32'(mq.size() == DEPTH));
    chk("empty",     empty,     32'(mq.size() == 0));
    chk("overflow",  overflow,  32'(m_ovf));
    chk("busy",      busy,      32'(m_have && (cyc - m_last) < F + G));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  // Monitor: every start pulse must carry the next expected character at the
  // expected edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_pulse: unexpected pulse data %0h, none required (cycle %0d)", datain_tx, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data",  datain_tx, 32'(e.d));
          chk("tx_cycle", cyc,       e.c);
        end
      end
    end
  end

  initial begin
    do_reset();

    // single character
    step(1'b1, 7'h55, 1'b0, 1'b0);
    idle(PER + 5);

    // three back-to-back writes
    step(1'b1, 7'h01, 1'b0, 1'b0);
    step(1'b1, 7'h02, 1'b0, 1'b0);
    step(1'b1, 7'h03, 1'b0, 1'b0);
    idle(3 * PER + 5);

    // overfill while the first frame is in flight
    step(1'b1, 7'h30, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 9; i++) step(1'b1, 7'(8'h31 + i), 1'b0, 1'b0);
    idle(9 * PER + 5);

    // write into a full FIFO on the same edge as the pop
    do_reset();
    step(1'b1, 7'h40, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 8; i++) step(1'b1, 7'(8'h41 + i), 1'b0, 1'b0);
    while (cyc + 1 < m_last + PER) idle(1);
    step(1'b1, 7'h49, 1'b0, 1'b0);
    idle(9 * PER + 5);

    // flush with a simultaneous write during HOLD
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 7'(8'h60 + i), 1'b0, 1'b0);
    idle(5);
    step(1'b1, 7'h7F, 1'b1, 1'b0);
    idle(PER + 10);

    // reset mid-HOLD with characters queued
    for (int i = 0; i < 4; i++) step(1'b1, 7'(8'h70 + i), 1'b0, 1'b0);
    idle(10);
    step(1'b0, '0, 1'b0, 1'b1);
    idle(PER + 10);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 5) == 0, 7'($urandom), $urandom_range(0, 99) == 0,
           $urandom_range(0, 399) == 0);
    end
    idle(9 * PER + 5);

    chk("pending_pulses", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
